// File: rtl/gru_seq_feeder.sv
// Two-bank ping-pong sequence buffer that replays each stored sequence into the GRU cell
// with first/last markers. Optional zero-padding to SEQ_LEN steps: define GRU_FEEDER_PAD_EN.
module gru_seq_feeder #(
    parameter int WIDTH   = 16,
    parameter int X_SIZE  = 6,
    parameter int SEQ_LEN = 15,
    parameter int IDX_W   = $clog2(SEQ_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x [0:X_SIZE-1],
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x [0:X_SIZE-1],
    output logic                    out_first,
    output logic                    out_last,
    output logic                    out_pad,
    output logic [IDX_W-1:0]        out_step,
    output logic                    seq_done
);

`ifdef GRU_FEEDER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic {IDLE, STREAM} rd_state_e;

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SEQ_LEN - 1);

    logic signed [WIDTH-1:0] mem [0:1][0:SEQ_LEN-1][0:X_SIZE-1];
    logic [IDX_W-1:0]        len [0:1];
    logic [1:0]              full, full_d;
    logic                    wr_bank;
    logic [IDX_W-1:0]        wr_idx;
    logic                    wr_accept, wr_close;

    rd_state_e               state, state_d;
    logic                    rd_bank;
    logic [IDX_W-1:0]        rd_idx;
    logic                    rd_release;
    logic                    load;
    logic                    load_bank;
    logic [IDX_W-1:0]        load_idx;
    logic                    load_first, load_last, load_pad;

    function automatic logic [IDX_W-1:0] final_idx(input logic [IDX_W-1:0] l);
        return PAD_EN ? LAST_SLOT : l - IDX_W'(1);
    endfunction

    // ---------------- write side ----------------
    assign in_ready  = !full[wr_bank];
    assign wr_accept = in_valid && in_ready;
    assign wr_close  = wr_accept && (in_last || wr_idx == LAST_SLOT);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    // NOTE: storage and lengths carry no reset; the full flags gate every read of them.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int j = 0; j < X_SIZE; j++) begin
                mem[wr_bank][wr_idx][j] <= in_x[j];
            end
            if (wr_close) begin
                len[wr_bank] <= wr_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            full <= full_d;
            if (wr_close) begin
                wr_idx  <= '0;
                wr_bank <= !wr_bank;
            end else if (wr_accept) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

    // Release and close always target different banks, so both may land in one cycle.
    always_comb begin
        full_d = full;
        if (rd_release) full_d[rd_bank] = 1'b0;
        if (wr_close)   full_d[wr_bank] = 1'b1;
    end

    // ---------------- read side ----------------
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state;
        load       = 1'b0;
        load_bank  = rd_bank;
        load_idx   = '0;
        rd_release = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_last) begin
                        rd_release = 1'b1;
                        if (full[!rd_bank]) begin
                            load      = 1'b1;
                            load_bank = !rd_bank;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        load     = 1'b1;
                        load_idx = rd_idx + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    assign load_first = (load_idx == '0);
    assign load_last  = (load_idx == final_idx(len[load_bank]));
    assign load_pad   = PAD_EN && (load_idx >= len[load_bank]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            seq_done  <= 1'b0;
            for (int j = 0; j < X_SIZE; j++) begin
                out_x[j] <= '0;
            end
        end else begin
            state    <= state_d;
            seq_done <= out_valid && out_ready && out_last;
            if (rd_release) begin
                rd_bank <= !rd_bank;
            end
            if (load) begin
                rd_idx    <= load_idx;
                out_first <= load_first;
                out_last  <= load_last;
                for (int j = 0; j < X_SIZE; j++) begin
                    out_x[j] <= load_pad ? '0 : mem[load_bank][load_idx][j];
                end
            end
        end
    end

`ifdef GRU_FEEDER_PAD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pad <= 1'b0;
        end else if (load) begin
            out_pad <= load_pad;
        end
    end
`else
    assign out_pad = 1'b0;
`endif

    assign out_valid = (state == STREAM);
    assign out_step  = rd_idx;

endmodule

// File: tb/tb_gru_seq_feeder.sv
// Directed, self-checking bench for gru_seq_feeder: table-driven sequence vectors plus
// hand-written stall, truncation and mid-stream reset sequences.
module tb_gru_seq_feeder;
    localparam int WIDTH   = 16;
    localparam int X_SIZE  = 6;
    localparam int SEQ_LEN = 15;
    localparam int IDX_W   = $clog2(SEQ_LEN + 1);
    localparam int XW      = X_SIZE * WIDTH;

`ifdef GRU_FEEDER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_last = 1'b0;
    logic                    out_ready = 1'b0;
    logic                    in_ready, out_valid, out_first, out_last, out_pad, seq_done;
    logic signed [WIDTH-1:0] in_x [0:X_SIZE-1];
    logic signed [WIDTH-1:0] out_x [0:X_SIZE-1];
    logic [IDX_W-1:0]        out_step;

    gru_seq_feeder #(.WIDTH(WIDTH), .X_SIZE(X_SIZE), .SEQ_LEN(SEQ_LEN), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
        .out_first(out_first), .out_last(out_last), .out_pad(out_pad),
        .out_step(out_step), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        int             step;
        bit             first, last, pad;
        logic [XW-1:0]  x;
    } beat_t;

    typedef struct {
        int n;
        bit use_last;
        int exp_beats;
        int exp_last_step;
    } vec_t;

    beat_t beats[$];
    int    done_cycs[$];
    int    errors = 0;
    int    checks = 0;

    function automatic logic [WIDTH-1:0] val(input int s, input int t, input int j);
        return WIDTH'(s * 256 + 16 * t + j);
    endfunction

    function automatic logic [XW-1:0] exp_x(input int s, input int t);
        logic [XW-1:0] x;
        for (int j = 0; j < X_SIZE; j++) x[j*WIDTH +: WIDTH] = val(s, t, j);
        return x;
    endfunction

    function automatic logic [XW-1:0] cur_x();
        logic [XW-1:0] x;
        for (int j = 0; j < X_SIZE; j++) x[j*WIDTH +: WIDTH] = out_x[j];
        return x;
    endfunction

    function automatic logic [127:0] word(input int off, input int step, input bit first,
                                          input bit last, input bit pad, input logic [XW-1:0] x);
        logic [127:0] w;
        w            = '0;
        w[XW-1:0]    = x;
        w[XW +: 3]   = {first, last, pad};
        w[XW+3 +: 8] = step[7:0];
        w[XW+11 +: 8] = off[7:0];
        return w;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accepted output beats and seq_done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            beat_t b;
            b.cyc   = cyc;
            b.step  = int'(out_step);
            b.first = out_first;
            b.last  = out_last;
            b.pad   = out_pad;
            b.x     = cur_x();
            beats.push_back(b);
        end
        if (!reset && seq_done) done_cycs.push_back(cyc);
    end

    task automatic send_seq(input int s, input int n, input bit use_last, output int close_cyc);
        close_cyc = -1;
        for (int t = 0; t < n; t++) begin
            in_valid = 1'b1;
            in_last  = use_last && (t == n - 1);
            for (int j = 0; j < X_SIZE; j++) in_x[j] = val(s, t, j);
            for (int b = 0; b < 200 && !in_ready; b++) begin
                @(posedge clk); #1;
            end
            if (!in_ready) begin
                check($sformatf("send_ready_timeout_s%0d_t%0d", s, t), in_ready, 1'b1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        close_cyc = cyc;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && beats.size() < n; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // Compares one replayed sequence against the expected stream derived from its write data.
    task automatic check_beats(input string name, input int base, input int s, input int toff,
                               input int n_real);
        int count;
        count = PAD ? SEQ_LEN : n_real;
        for (int k = 0; k < count; k++) begin
            if (base + k < beats.size()) begin
                beat_t b;
                bit    p;
                b = beats[base + k];
                p = (k >= n_real);
                check($sformatf("%s_beat%0d", name, k),
                      word(b.cyc - beats[base].cyc, b.step, b.first, b.last, b.pad, b.x),
                      word(k, k, k == 0, k == count - 1, PAD && p, p ? '0 : exp_x(s, toff + k)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   c_a, c_b, c_c, c_d, c_e;

        vecs[0] = '{15, 1'b1, 15, 14};
        vecs[1] = '{5,  1'b1, PAD ? 15 : 5, PAD ? 14 : 4};
        vecs[2] = '{1,  1'b1, PAD ? 15 : 1, PAD ? 14 : 0};
        vecs[3] = '{15, 1'b0, 15, 14};
        vecs[4] = '{9,  1'b1, PAD ? 15 : 9, PAD ? 14 : 8};

        for (int j = 0; j < X_SIZE; j++) in_x[j] = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_first", out_first, 1'b0);
        check("rst_out_last",  out_last,  1'b0);
        check("rst_out_pad",   out_pad,   1'b0);
        check("rst_out_step",  out_step,  '0);
        check("rst_out_x",     cur_x(),   '0);
        check("rst_seq_done",  seq_done,  1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ---- table-driven single sequences, consumer always ready ----
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            beats.delete();
            done_cycs.delete();
            send_seq(i, vecs[i].n, vecs[i].use_last, c_a);
            wait_beats(vecs[i].exp_beats, 100);
            check($sformatf("v%0d_beat_count", i), beats.size(), vecs[i].exp_beats);
            if (beats.size() > 0) begin
                check($sformatf("v%0d_first_latency", i), beats[0].cyc - c_a, 1);
                check($sformatf("v%0d_last_step", i), beats[beats.size()-1].step,
                      vecs[i].exp_last_step);
            end
            check_beats($sformatf("v%0d", i), 0, i, 0, vecs[i].n);
            check($sformatf("v%0d_done_count", i), done_cycs.size(), 1);
            if (done_cycs.size() > 0 && beats.size() > 0)
                check($sformatf("v%0d_done_cycle", i), done_cycs[0] - beats[beats.size()-1].cyc, 1);
        end

        // ---- both banks filled under stall, release, third sequence ----
        beats.delete();
        done_cycs.delete();
        out_ready = 1'b0;
        send_seq(100, 15, 1'b1, c_a);
        send_seq(101, 15, 1'b1, c_b);
        check("stall_in_ready_full", in_ready,  1'b0);
        check("stall_out_valid",     out_valid, 1'b1);
        check("stall_out_first",     out_first, 1'b1);
        check("stall_out_step0",     out_step,  '0);
        check("stall_out_x0",        cur_x(),   exp_x(100, 0));
        in_valid = 1'b1;
        for (int j = 0; j < X_SIZE; j++) in_x[j] = val(102, 0, j);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("stall_in_ready_held", in_ready, 1'b0);
        check("stall_out_x_held",    cur_x(),  exp_x(100, 0));
        check("stall_out_step_held", out_step, '0);
        check("stall_no_beats",      beats.size(), 0);
        out_ready = 1'b1;
        repeat (14) begin
            @(posedge clk); #1;
        end
        check("release_in_ready_before", in_ready, 1'b0);
        @(posedge clk); #1;
        check("release_in_ready_after", in_ready, 1'b1);
        send_seq(102, 15, 1'b1, c_c);
        wait_beats(45, 120);
        check("queued_beat_count", beats.size(), 45);
        check_beats("qa", 0,  100, 0, 15);
        check_beats("qb", 15, 101, 0, 15);
        check_beats("qc", 30, 102, 0, 15);
        if (beats.size() >= 45) begin
            check("queued_no_bubble_15", beats[15].cyc - beats[0].cyc, 15);
            check("queued_no_bubble_29", beats[29].cyc - beats[0].cyc, 29);
            check("close_during_release_latency", beats[30].cyc - c_c, 1);
        end
        check("queued_done_count", done_cycs.size(), 3);

        // ---- 20 beats without in_last until beat 19: truncation at SEQ_LEN ----
        beats.delete();
        done_cycs.delete();
        send_seq(200, 20, 1'b1, c_d);
        wait_beats(15 + (PAD ? 15 : 5), 100);
        check("trunc_beat_count", beats.size(), 15 + (PAD ? 15 : 5));
        check_beats("trunc_a", 0,  200, 0,  15);
        check_beats("trunc_b", 15, 200, 15, 5);
        if (beats.size() > 15)
            check("trunc_no_bubble", beats[15].cyc - beats[0].cyc, 15);

        // ---- reset in the middle of a stream with a second sequence queued ----
        out_ready = 1'b0;
        send_seq(300, 15, 1'b1, c_e);
        send_seq(301, 15, 1'b1, c_e);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !(out_valid && out_step == IDX_W'(7)); i++) begin
            @(posedge clk); #1;
        end
        check("mid_reached_step7", out_step, IDX_W'(7));
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready",  in_ready,  1'b1);
        check("mid_rst_out_step",  out_step,  '0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_queued_discarded", out_valid, 1'b0);
        beats.delete();
        done_cycs.delete();
        send_seq(302, 4, 1'b1, c_e);
        wait_beats(PAD ? 15 : 4, 100);
        check("post_rst_beat_count", beats.size(), PAD ? 15 : 4);
        if (beats.size() > 0)
            check("post_rst_latency", beats[0].cyc - c_e, 1);
        check_beats("post_rst", 0, 302, 0, 4);
        check("post_rst_done_count", done_cycs.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gru_seq_feeder.md
# gru_seq_feeder

Sequence front-end for the GRU tagger datapath. It accepts per-timestep feature vectors from an upstream track source and buffers each complete sequence in a two-bank ping-pong store. It then replays the sequence into the GRU cell input one timestep per accepted beat, with first/last markers. These markers let the consumer clear the hidden state at sequence start and capture the final hidden state at sequence end.

## Interface
Parameters:
- WIDTH, 16, feature word width (signed fixed point, format opaque to this block)
- X_SIZE, 6, features per timestep
- SEQ_LEN, 15, timesteps per sequence
- IDX_W, $clog2(SEQ_LEN+1), width of timestep index/length fields

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  write bank available
- in_x  in  signed [WIDTH-1:0] [0:X_SIZE-1]  one timestep of features
- in_last  in  1  beat is last real timestep of this sequence
- out_valid  out  1  x_t beat valid
- out_ready  in  1  consumer accepts beat
- out_x  out  signed [WIDTH-1:0] [0:X_SIZE-1]  timestep to GRU cell
- out_first  out  1  beat is timestep 0
- out_last  out  1  beat is final emitted timestep
- out_pad  out  1  beat is zero padding
- out_step  out  IDX_W  timestep index of current beat
- seq_done  out  1  one-cycle pulse on acceptance of out_last beat

## Operation
- Storage: 2 banks × SEQ_LEN entries × X_SIZE×WIDTH. Each bank has a full flag and a length register len (1..SEQ_LEN).
- Write side: wr_bank, wr_idx. in_ready = !full[wr_bank]. A beat is accepted on in_valid && in_ready and is written to entry wr_idx.
  - The sequence closes when the accepted beat has in_last=1 or wr_idx==SEQ_LEN-1. On close: len=wr_idx+1, full[wr_bank]=1, wr_idx=0, wr_bank toggles.
  - Otherwise wr_idx increments.
  - With no in_last, the sequence closes at SEQ_LEN. Later beats belong to the next sequence, so upstream sequences are truncated and never merged.
- Read FSM: IDLE, STREAM.
  - IDLE: when full[rd_bank], load step 0 and go to STREAM.
  - STREAM: a beat is accepted on out_valid && out_ready. On a non-final beat, rd_idx increments.
  - On the final beat: clear full[rd_bank] and toggle rd_bank. If the other bank is full, load its step 0 in the same cycle and stay in STREAM (no bubble). Otherwise go to IDLE and out_valid falls.
- Final step index: SEQ_LEN-1 with padding, len-1 without (see Configuration).
- Padding steps (rd_idx ≥ len): out_x=0, out_pad=1.
- Output register loads when !out_valid || out_ready. While out_valid && !out_ready, all out_* hold stable.
- Simultaneous events:
  - Read release and write close in the same cycle: both take effect.
  - Write into a bank in the same cycle it is released: not possible, because in_ready reflects the registered full flag. The write is accepted the next cycle.
- Reset: full[1:0]=0, wr_idx=rd_idx=0, wr_bank=rd_bank=0, FSM=IDLE. Any partial or queued sequence is discarded; storage contents are not cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_first=0, out_last=0, out_pad=0, out_step=0, out_x=0, seq_done=0.
- Closing write accepted at edge E sets full at E. out_valid with out_first rises at edge E+1 when the read side is IDLE.
- Throughput: 1 timestep/cycle while out_ready=1. Continuous across banks.
- seq_done asserts in the cycle after the out_last beat is accepted, for exactly 1 cycle.
- Write throughput: 1 beat/cycle until both banks are full.

## Configuration
- GRU_FEEDER_PAD_EN defined: every sequence emits exactly SEQ_LEN beats. Steps ≥ len are zero with out_pad=1; out_last is at step SEQ_LEN-1. This matches the fixed-count GRU sequence counter.
- GRU_FEEDER_PAD_EN undefined: a sequence emits len beats and out_last is at step len-1. out_pad is tied 0 and the zero-fill mux is removed.

## Test plan
- Full sequence, x[t][j]=16t+j, out_ready=1 → 15 beats in consecutive cycles, first at t=0, last at t=14, out_valid rises 1 cycle after the closing write, seq_done 1 cycle after the last beat.
- in_last at t=4, PAD_EN defined → 15 beats, steps 5..14 have out_x=0 and out_pad=1. PAD_EN undefined → 5 beats, out_last at step 4.
- Three back-to-back sequences with out_ready=0 → in_ready=0 after 30 accepted beats. Raise out_ready → in_ready returns 1 the cycle after the first bank releases. Held out_x is unchanged throughout the stall.
- Two queued banks with out_ready=1 → out_valid high for 30 consecutive cycles, out_first at cycles 0 and 15, out_last at cycles 14 and 29.
- 20 beats with no in_last → first sequence closes at 15 beats. Beats 15..19 form steps 0..4 of the second sequence.
- reset asserted at out_step=7 → next cycle out_valid=0 and in_ready=1. The following sequence starts at out_step=0 with out_first=1.
